seg_display_ctrl: RTL
=====================

// Module: seg_display_ctrl
// PURPOSE
//   Parametrised N-digit seven-segment display controller: samples a binary value on a load strobe and
//   converts it to BCD with a multi-cycle double-dabble. It then time-multiplexes the digits onto the
//   segment/anode pins, and flags values that do not fit. Top-level display sink for any numeric result.
// PARAMETERS
//   BIN_W        11     width of binary input
//   DIGITS       4      number of BCD digits / anodes driven (1..8)
//   REFRESH_DIV  50000  clock cycles each digit stays lit (>=2)
// PORTS
//   clock     in   1          system clock, all state on rising edge
//   reset     in   1          asynchronous, active-low reset
//   entry     in   BIN_W      binary value, sampled on accepted load
//   load      in   1          one-cycle request to convert entry
//   busy      out  1          conversion in progress; load ignored while high
//   overflow  out  1          displayed value exceeded 10^DIGITS-1
//   seg       out  7          {a,b,c,d,e,f,g}, active-low (0 = lit)
//   an        out  DIGITS     digit enables, active-low one-hot, an[0] = least significant digit
// BEHAVIOUR
//   Reset (async assert, sync release): busy=0, overflow=0, display regs=0, scan index=0, refresh cnt=0,
//     an=all 1s, seg=7'h7F; conversion aborted. First scan slot starts one cycle after release.
//   Converter FSM (in sub-module): IDLE -> SHIFT (BIN_W cycles) -> DONE (1 cycle) -> IDLE.
//     IDLE: load=1 captures entry, busy=1 next cycle. Load in SHIFT/DONE dropped, never queued.
//     SHIFT: per cycle, add 3 to every nibble >=5, then shift left 1 with next entry MSB.
//     Work register holds DIGITS+1 nibbles; any 1 shifted out of the top nibble sets sticky ovf bit.
//     DONE: display regs <- low DIGITS nibbles; overflow <- (top nibble!=0)|ovf; busy=0 same edge.
//     Latency: load edge to display update = BIN_W+1 cycles; back-to-back load accepted cycle after DONE.
//   Display regs change only in DONE: no partial/torn digits ever shown.
//   Scan: refresh cnt 0..REFRESH_DIV-1; on wrap index <- (index==DIGITS-1)?0:index+1.
//     an = ~(1<<index); seg = decode(display digit[index]), registered with an.
//   Decode: 0-9 standard patterns; nibble >9 unreachable, map to blank.
//   overflow=1: every digit shows dash (only g lit, seg=7'b1111110) until a non-overflow conversion.
//   entry=0 -> all digits '0' (subject to blanking below); max entry 2^BIN_W-1 handled by ovf rule.
// CONFIGURATION
//   LEADING_ZERO_BLANK_EN defined: digits above the most significant non-zero digit show seg=7'h7F
//     (anode still scanned); digit 0 is never blanked, so value 0 shows "   0". Ignored when overflow=1.
//   Not defined: all DIGITS digits always shown, leading zeros included ("0007").
// STRUCTURE
//   seg_display_pkg: converter state encoding (IDLE/SHIFT/DONE), 7-seg pattern constants for 0-9, dash,
//     blank, and a decode function nibble->seg.
//   Sub-module bin_to_bcd_seq: sequential double-dabble (clock, reset, entry, load, busy, bcd, ovf, done);
//     top holds display regs, refresh counter, scan index, blanking and output registers.
// TESTING
//   1 DIGITS=4, entry=1234, load 1 cycle -> busy high 12 cycles; display regs 4,3,2,1; overflow=0;
//     seg for an=1110 is 7'b1001100.
//   2 REFRESH_DIV=4 -> an steps 1110,1101,1011,0111 every 4 cycles, wraps back to 1110.
//   3 DIGITS=3, entry=1000 -> overflow=1, all three digits seg=7'b1111110. Then entry=999 -> overflow=0.
//   4 entry=7: with LEADING_ZERO_BLANK_EN digits 3..1 seg=7'h7F, digit0 '7'.
//     Without it, digits 3..1 show '0'.
//   5 load=1 with entry=5, then load=1 with entry=9 three cycles later -> second load ignored; shows 5.
//   6 reset low mid-SHIFT (cycle 5 of 11) -> busy=0, an=all 1s, seg=7'h7F immediately.
//     After release, display shows zero and the next load converts correctly.

Source files
------------

// File: rtl/seg_display_pkg.sv
// Shared types and seven-segment constants for the seg_display_ctrl block.
// Segment order is {a,b,c,d,e,f,g}. Segments are active-low, so a 0 bit lights that segment.
package seg_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } conv_state_t;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg_display_ctrl_if.sv
// Bundles the load/status/display pins of seg_display_ctrl.
// The controller is the slave; the value source and the pin consumer are the master.
interface seg_display_ctrl_if #(
  parameter int unsigned BIN_W  = 11,
  parameter int unsigned DIGITS = 4
);
  logic [BIN_W-1:0]  entry;
  logic              load;
  logic              busy;
  logic              overflow;
  logic [6:0]        seg;
  logic [DIGITS-1:0] an;

  modport master (output entry, load, input busy, overflow, seg, an);
  modport slave  (input entry, load, output busy, overflow, seg, an);
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter. It performs one shift per cycle and uses DIGITS+1 BCD nibbles.
// Any carry out of the spare top nibble is recorded as a sticky overflow.
module bin_to_bcd_seq
  import seg_display_pkg::*;
#(
  parameter int unsigned BIN_W  = 11,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [BIN_W-1:0]      entry,
  input  logic                  load,
  output logic                  busy,
  output logic [DIGITS*4-1:0]   bcd,
  output logic                  ovf,
  output logic                  done
);

  localparam int unsigned WORK_W = (DIGITS + 1) * 4;
  localparam int unsigned CNT_W  = $clog2(BIN_W + 1);

  conv_state_t       state, state_nxt;
  logic [BIN_W-1:0]  src;
  logic [WORK_W-1:0] work, work_adj;
  logic              lost;
  logic [CNT_W-1:0]  cnt;
  logic              last_shift;

  assign last_shift = (cnt == CNT_W'(BIN_W - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = SHIFT;
      SHIFT:   if (last_shift) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // The work register starts at zero, so adjusting before the shift gives the classic algorithm.
  always_comb begin
    work_adj = work;
    for (int unsigned i = 0; i < DIGITS + 1; i++) begin
      if (work[i*4 +: 4] >= 4'd5) work_adj[i*4 +: 4] = work[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      src  <= '0;
      work <= '0;
      lost <= 1'b0;
      cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (load) begin
          src  <= entry;
          work <= '0;
          lost <= 1'b0;
          cnt  <= '0;
        end
        SHIFT: begin
          work <= {work_adj[WORK_W-2:0], src[BIN_W-1]};
          src  <= src << 1;
          lost <= lost | work_adj[WORK_W-1];
          cnt  <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bcd = work[DIGITS*4-1:0];
  assign ovf = lost | (work[WORK_W-1 -: 4] != 4'd0);

endmodule

// File: rtl/seg_display_ctrl.sv
// N-digit seven-segment controller: performs BCD conversion on load and multiplexes the digits onto seg/an.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zeros. Digit 0 is never blanked.
module seg_display_ctrl
  import seg_display_pkg::*;
#(
  parameter int unsigned BIN_W       = 11,
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input logic               clock,
  input logic               reset,
  seg_display_ctrl_if.slave bus
);

  localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned RCNT_W = $clog2(REFRESH_DIV);

  logic [DIGITS*4-1:0] bcd, disp;
  logic                conv_ovf, conv_done, ovf_r;
  logic [RCNT_W-1:0]   rcnt;
  logic [IDX_W-1:0]    idx;
  logic [3:0]          cur_nib;
  logic                cur_blank;
  logic [6:0]          seg_nxt, seg_r;
  logic [DIGITS-1:0]   an_r;

  bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) u_conv (
    .clock (clock),
    .reset (reset),
    .entry (bus.entry),
    .load  (bus.load),
    .busy  (bus.busy),
    .bcd   (bcd),
    .ovf   (conv_ovf),
    .done  (conv_done)
  );

  // The display is loaded only from a finished conversion, so a partially converted value is never shown.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      disp  <= '0;
      ovf_r <= 1'b0;
    end else if (conv_done) begin
      disp  <= bcd;
      ovf_r <= conv_ovf;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rcnt <= '0;
      idx  <= '0;
    end else if (rcnt == RCNT_W'(REFRESH_DIV - 1)) begin
      rcnt <= '0;
      idx  <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      rcnt <= rcnt + RCNT_W'(1);
    end
  end

  always_comb begin
    cur_nib   = '0;
    cur_blank = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib = disp[i*4 +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        cur_blank = (i != 0) && ((disp >> (i * 4)) == '0);
`endif
      end
    end
  end

  always_comb begin
    if (ovf_r)          seg_nxt = SEG_DASH;
    else if (cur_blank) seg_nxt = SEG_BLANK;
    else                seg_nxt = seg_decode(cur_nib);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      an_r  <= '1;
      seg_r <= SEG_BLANK;
    end else begin
      an_r  <= ~(DIGITS'(1) << idx);
      seg_r <= seg_nxt;
    end
  end

  assign bus.an       = an_r;
  assign bus.seg      = seg_r;
  assign bus.overflow = ovf_r;

endmodule
